// File: rtl/key_press_classifier_pkg.sv
// Shared types and default timing constants for the key press classifier.
// Holds the per-key state encoding and a counter-width helper.
package key_pkg;

    typedef enum logic [1:0] {
        LOCK    = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        HELD    = 2'd3
    } key_state_t;

    localparam int CLK_50M_PER_MS = 50_000;
    localparam int LONG_MS_DEF    = 1000;
    localparam int REPEAT_MS_DEF  = 200;

    // Width of a counter spanning 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_press_classifier_fsm.sv
// Single-key classifier: LOCK/IDLE/PRESSED/HELD FSM producing registered
// one-cycle short/long/repeat pulses plus a held level.
// Ports: clk, rst_n (sync, active-low), i_ms_tick (shared 1 ms strobe),
//   i_pressed (1 = key down), o_short_press, o_long_press,
//   o_repeat_press, o_key_held.
// Macro KEY_REPEAT_EN: enables the auto-repeat counter in HELD.
module key_press_fsm
    import key_pkg::*;
#(
    parameter int LONG_MS   = LONG_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ms_tick,
    input  logic i_pressed,
    output logic o_short_press,
    output logic o_long_press,
    output logic o_repeat_press,
    output logic o_key_held
);

    localparam int HW = cnt_w(LONG_MS);

    key_state_t     r_state;
    key_state_t     w_state_nxt;
    logic [HW-1:0]  r_hold_cnt;
    logic [HW-1:0]  w_hold_cnt_nxt;
    logic           w_short;
    logic           w_long;
    logic           r_short;
    logic           r_long;
    logic           r_held;

`ifdef KEY_REPEAT_EN
    localparam int RW = cnt_w(REPEAT_MS);

    logic [RW-1:0]  r_rep_cnt;
    logic [RW-1:0]  w_rep_cnt_nxt;
    logic           w_rep;
    logic           r_rep;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_short        = 1'b0;
        w_long         = 1'b0;
`ifdef KEY_REPEAT_EN
        w_rep_cnt_nxt  = r_rep_cnt;
        w_rep          = 1'b0;
`endif
        case (r_state)
            LOCK: begin
                if (!i_pressed)
                    w_state_nxt = IDLE;
            end
            IDLE: begin
                if (i_pressed) begin
                    w_state_nxt    = PRESSED;
                    w_hold_cnt_nxt = '0;
                end
            end
            PRESSED: begin
                // Release is checked first so it wins over the threshold.
                if (!i_pressed) begin
                    w_short     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (i_ms_tick) begin
                    if (r_hold_cnt == HW'(LONG_MS - 1)) begin
                        w_long      = 1'b1;
                        w_state_nxt = HELD;
`ifdef KEY_REPEAT_EN
                        w_rep_cnt_nxt = '0;
`endif
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                    end
                end
            end
            HELD: begin
                if (!i_pressed) begin
                    w_state_nxt = IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (i_ms_tick) begin
                    if (r_rep_cnt == RW'(REPEAT_MS - 1)) begin
                        w_rep         = 1'b1;
                        w_rep_cnt_nxt = '0;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                    end
                end
`endif
            end
            default: w_state_nxt = LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= LOCK;
            r_hold_cnt <= '0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_short    <= w_short;
            r_long     <= w_long;
            r_held     <= (w_state_nxt == HELD);
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
            r_rep     <= 1'b0;
        end else begin
            r_rep_cnt <= w_rep_cnt_nxt;
            r_rep     <= w_rep;
        end
    end

    assign o_repeat_press = r_rep;
`else
    assign o_repeat_press = 1'b0;
`endif

    assign o_short_press = r_short;
    assign o_long_press  = r_long;
    assign o_key_held    = r_held;

    a_legal_params: assert property (@(posedge clk)
        (LONG_MS >= 2) && (REPEAT_MS >= 1))
        else $error("key_press_fsm: illegal LONG_MS/REPEAT_MS");

endmodule

// File: rtl/key_press_classifier.sv
// Classifies debounced active-low keys into short/long/repeat pulses.
// Ports: clk, rst_n (sync, active-low), key_level[KEY_NUM] (0 = pressed),
//   short_press, long_press, repeat_press (1-cycle pulses), key_held (level).
// Macro KEY_REPEAT_EN: enables repeat_press; otherwise it is tied to 0.
module key_press_classifier
    import key_pkg::*;
#(
    parameter int KEY_NUM    = 3,
    parameter int CLK_PER_MS = CLK_50M_PER_MS,
    parameter int LONG_MS    = LONG_MS_DEF,
    parameter int REPEAT_MS  = REPEAT_MS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] short_press,
    output logic [KEY_NUM-1:0] long_press,
    output logic [KEY_NUM-1:0] repeat_press,
    output logic [KEY_NUM-1:0] key_held
);

    localparam int MW = cnt_w(CLK_PER_MS);

    logic [MW-1:0] r_ms_cnt;
    logic          w_ms_tick;

    // One prescaler shared by every key keeps all keys on the same ms grid.
    assign w_ms_tick = (r_ms_cnt == MW'(CLK_PER_MS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ms_cnt <= '0;
        else if (w_ms_tick)
            r_ms_cnt <= '0;
        else
            r_ms_cnt <= r_ms_cnt + 1'b1;
    end

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
        key_press_fsm #(
            .LONG_MS   (LONG_MS),
            .REPEAT_MS (REPEAT_MS)
        ) u_fsm (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_ms_tick      (w_ms_tick),
            .i_pressed      (~key_level[g]),
            .o_short_press  (short_press[g]),
            .o_long_press   (long_press[g]),
            .o_repeat_press (repeat_press[g]),
            .o_key_held     (key_held[g])
        );
    end

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier with a tick-counting reference model.
// Build with or without KEY_REPEAT_EN; expectations adapt.
module tb_key_press_classifier;

    localparam int KN  = 3;
    localparam int CPM = 10;
    localparam int LMS = 20;
    localparam int RMS = 5;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KN-1:0] key_level = '1;
    logic [KN-1:0] short_press;
    logic [KN-1:0] long_press;
    logic [KN-1:0] repeat_press;
    logic [KN-1:0] key_held;

    always #5 clk = ~clk;

    key_press_classifier #(
        .KEY_NUM    (KN),
        .CLK_PER_MS (CPM),
        .LONG_MS    (LMS),
        .REPEAT_MS  (RMS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_level    (key_level),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_press (repeat_press),
        .key_held     (key_held)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: counts ms ticks seen while a key is down and
    // derives events from that count alone.
    int            m_cyc = 0;
    bit            m_lock [KN];
    bit            m_act  [KN];
    int            m_ticks[KN];
    bit            started = 1'b0;
    logic [KN-1:0] e_short = '0;
    logic [KN-1:0] e_long  = '0;
    logic [KN-1:0] e_rep   = '0;
    logic [KN-1:0] e_held  = '0;

    always @(posedge clk) begin
        bit tick;
        bit pr;
        e_short = '0;
        e_long  = '0;
        e_rep   = '0;
        e_held  = '0;
        if (!rst_n) begin
            m_cyc   = 0;
            started = 1'b1;
            for (int i = 0; i < KN; i++) begin
                m_lock[i]  = 1'b1;
                m_act[i]   = 1'b0;
                m_ticks[i] = 0;
            end
        end else begin
            tick = ((m_cyc % CPM) == CPM - 1);
            m_cyc++;
            for (int i = 0; i < KN; i++) begin
                pr = !key_level[i];
                if (m_lock[i]) begin
                    if (!pr) m_lock[i] = 1'b0;
                end else if (!m_act[i]) begin
                    if (pr) begin
                        m_act[i]   = 1'b1;
                        m_ticks[i] = 0;
                    end
                end else if (!pr) begin
                    if (m_ticks[i] < LMS) e_short[i] = 1'b1;
                    m_act[i] = 1'b0;
                end else if (tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == LMS)
                        e_long[i] = 1'b1;
                    else if (REP_EN && m_ticks[i] > LMS &&
                             ((m_ticks[i] - LMS) % RMS) == 0)
                        e_rep[i] = 1'b1;
                end
                e_held[i] = m_act[i] && (m_ticks[i] >= LMS);
            end
        end
    end

    int cnt_short[KN];
    int cnt_long [KN];
    int cnt_rep  [KN];

    always @(negedge clk) begin
        if (started) begin
            check("short_press",  32'(short_press),  32'(e_short));
            check("long_press",   32'(long_press),   32'(e_long));
            check("repeat_press", 32'(repeat_press), 32'(e_rep));
            check("key_held",     32'(key_held),     32'(e_held));
            for (int i = 0; i < KN; i++) begin
                cnt_short[i] += int'(short_press[i]);
                cnt_long[i]  += int'(long_press[i]);
                cnt_rep[i]   += int'(repeat_press[i]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < KN; i++) begin
            cnt_short[i] = 0;
            cnt_long[i]  = 0;
            cnt_rep[i]   = 0;
        end
    endtask

    // Puts the next sampling edge right after an ms tick.
    task automatic align();
        for (int k = 0; k < CPM && (m_cyc % CPM) != 0; k++)
            step(1);
    endtask

    initial begin
        clr_cnt();
        key_level    = '1;
        key_level[0] = 1'b0;
        rst_n        = 1'b0;
        step(3);
        rst_n = 1'b1;

        // Key held across reset: locked, silent.
        step(300);
        key_level[0] = 1'b1;
        step(5);
        check("lock_short0", 32'(cnt_short[0]), 32'd0);
        check("lock_long0",  32'(cnt_long[0]),  32'd0);
        key_level[0] = 1'b0;
        step(50);
        key_level[0] = 1'b1;
        step(5);
        check("post_lock_short0", 32'(cnt_short[0]), 32'd1);

        // Short press on key 1, exact pulse timing.
        clr_cnt();
        key_level[1] = 1'b0;
        step(100);
        key_level[1] = 1'b1;
        step(1);
        check("short1_pulse", 32'(short_press), 32'h2);
        step(1);
        check("short1_gone", 32'(short_press), 32'h0);
        step(5);
        check("short1_count", 32'(cnt_short[1]), 32'd1);
        check("short1_nolong", 32'(cnt_long[1]), 32'd0);

        // Long press on key 2.
        clr_cnt();
        key_level[2] = 1'b0;
        step(220);
        check("held2_level", 32'(key_held), 32'h4);
        step(30);
        key_level[2] = 1'b1;
        step(5);
        check("long2_count",  32'(cnt_long[2]),  32'd1);
        check("long2_noshort", 32'(cnt_short[2]), 32'd0);
        check("held2_clear", 32'(key_held), 32'h0);

        // Auto-repeat on key 0.
        clr_cnt();
        align();
        key_level[0] = 1'b0;
        step(400);
        key_level[0] = 1'b1;
        step(5);
        check("rep0_long", 32'(cnt_long[0]), 32'd1);
        check("rep0_count", 32'(cnt_rep[0]), REP_EN ? 32'd4 : 32'd0);

        // Independent keys pressed together.
        clr_cnt();
        align();
        key_level = 3'b100;
        step(100);
        key_level[0] = 1'b1;
        step(150);
        key_level[1] = 1'b1;
        step(5);
        check("ind_short0", 32'(cnt_short[0]), 32'd1);
        check("ind_long1",  32'(cnt_long[1]),  32'd1);
        check("ind_short1", 32'(cnt_short[1]), 32'd0);
        check("ind_long0",  32'(cnt_long[0]),  32'd0);

        // Short on key 0 and long on key 1 in the same cycle.
        clr_cnt();
        align();
        key_level = 3'b100;
        step(199);
        key_level[0] = 1'b1;
        step(1);
        check("coin_short", 32'(short_press), 32'h1);
        check("coin_long",  32'(long_press),  32'h2);
        step(50);
        key_level[1] = 1'b1;
        step(5);

        // Release exactly on the threshold tick.
        clr_cnt();
        align();
        key_level[2] = 1'b0;
        step(199);
        key_level[2] = 1'b1;
        step(1);
        check("edge_short", 32'(short_press), 32'h4);
        check("edge_long",  32'(long_press),  32'h0);
        step(5);
        check("edge_long_cnt", 32'(cnt_long[2]), 32'd0);

        // Reset while a key is down: no pending event.
        clr_cnt();
        key_level[1] = 1'b0;
        step(100);
        rst_n = 1'b0;
        step(2);
        check("rst_outputs", 32'(short_press | long_press | key_held), 32'h0);
        rst_n = 1'b1;
        step(50);
        key_level[1] = 1'b1;
        step(5);
        check("rst_short1", 32'(cnt_short[1]), 32'd0);
        check("rst_long1",  32'(cnt_long[1]),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
